// File: rtl/pwm_capture.sv
// PWM measurement block: synchronizes one PWM line, measures period and high time in
// clock cycles, derives per-mille duty with a shift-subtract divider, and serves the results on a local-bus read port.
module pwm_capture #(
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MAX_PERIOD         = 4000
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          EN_I,
  input  logic                          PWM_I,
  output logic [11:0]                   PERIOD_O,
  output logic [11:0]                   HIGH_O,
  output logic [9:0]                    DUTY_O,
  output logic                          STUCK_O,
  output logic                          VALID_O,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] LB_RADDR,
  input  logic                          LB_RREQ,
  output logic [C_S_AXI_DATA_WIDTH-1:0] LB_RDATA,
  output logic                          LB_RFINISH
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DIV} state_t;

  localparam logic [11:0] CNT_MAX   = 12'hFFF;
  localparam logic [11:0] TMO_CNT   = 12'(MAX_PERIOD);
  localparam logic [9:0]  DUTY_FULL = 10'd1000;
  localparam logic [3:0]  DIV_LAST  = 4'd9;

  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_PERIOD = C_S_AXI_ADDR_WIDTH'('h0);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_HIGH   = C_S_AXI_ADDR_WIDTH'('h4);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_DUTY   = C_S_AXI_ADDR_WIDTH'('h8);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_STAT   = C_S_AXI_ADDR_WIDTH'('hC);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  function automatic logic [9:0] sat_duty(input logic [9:0] q);
    return (q > DUTY_FULL) ? DUTY_FULL : q;
  endfunction

  state_t      state, state_nxt;
  logic        s1, s2, s3;
  logic        rise, fall;
  logic [11:0] cnt;
  logic [11:0] high_lat, high_div, period_lat;
  logic [21:0] div_rem, div_d, div_rem_nxt;
  logic [8:0]  div_q;
  logic [9:0]  div_q_nxt;
  logic        div_take;
  logic [3:0]  div_idx;
  logic        new_flag;
  logic        clear, meas_hit, div_last, timeout, stat_rd;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;

  // Input synchronizer and edge detect
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= PWM_I;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign clear    = !EN_I || (state == IDLE);
  assign meas_hit = (state == MEAS) && rise;
  assign div_last = (state == DIV) && (div_idx == DIV_LAST);
  // Once stuck, the saturated counter must not re-trigger the timeout.
  assign timeout  = ((state == ARM) || (state == MEAS)) && !rise &&
                    (cnt == TMO_CNT) && !STUCK_O;
  assign stat_rd  = LB_RREQ && (LB_RADDR == ADDR_STAT);

  assign div_take    = (div_rem >= div_d);
  assign div_rem_nxt = div_take ? (div_rem - div_d) : div_rem;
  assign div_q_nxt   = {div_q, div_take};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!EN_I) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEAS;
        MEAS: begin
          if (rise)         state_nxt = DIV;
          else if (timeout) state_nxt = ARM;
        end
        DIV:     if (div_idx == DIV_LAST) state_nxt = MEAS;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counter, divider sequencing and result registers
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cnt      <= '0;
      div_idx  <= '0;
      PERIOD_O <= '0;
      HIGH_O   <= '0;
      DUTY_O   <= '0;
      STUCK_O  <= 1'b0;
      VALID_O  <= 1'b0;
      new_flag <= 1'b0;
    end else begin
      VALID_O <= 1'b0;
      if (clear) begin
        cnt      <= '0;
        div_idx  <= '0;
        PERIOD_O <= '0;
        HIGH_O   <= '0;
        DUTY_O   <= '0;
        STUCK_O  <= 1'b0;
        new_flag <= 1'b0;
      end else begin
        cnt <= rise ? 12'd1 : sat_inc(cnt);
        if (meas_hit)            div_idx <= '0;
        else if (state == DIV)   div_idx <= div_idx + 4'd1;
        if (stat_rd) new_flag <= 1'b0;
        if (div_last) begin
          PERIOD_O <= period_lat;
          HIGH_O   <= high_div;
          DUTY_O   <= sat_duty(div_q_nxt);
          STUCK_O  <= 1'b0;
          VALID_O  <= 1'b1;
          new_flag <= 1'b1;
        end
        if (timeout) begin
          PERIOD_O <= '0;
          HIGH_O   <= '0;
          DUTY_O   <= s2 ? DUTY_FULL : 10'd0;
          STUCK_O  <= 1'b1;
          VALID_O  <= 1'b1;
        end
      end
    end
  end

  // Measurement latches and divider datapath; H is frozen at the period rise
  // because falls during DIV keep updating high_lat.
  always_ff @(posedge S_AXI_ACLK) begin
    if (fall) high_lat <= cnt;
    if (meas_hit) begin
      period_lat <= cnt;
      high_div   <= high_lat;
      div_rem    <= 22'(high_lat) * 22'd1000;
      div_d      <= {1'b0, cnt, 9'b0};
      div_q      <= '0;
    end else if (state == DIV) begin
      div_rem <= div_rem_nxt;
      div_q   <= div_q_nxt[8:0];
      div_d   <= div_d >> 1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (LB_RADDR)
      ADDR_PERIOD: rd_mux = C_S_AXI_DATA_WIDTH'(PERIOD_O);
      ADDR_HIGH:   rd_mux = C_S_AXI_DATA_WIDTH'(HIGH_O);
      ADDR_DUTY:   rd_mux = C_S_AXI_DATA_WIDTH'(DUTY_O);
      ADDR_STAT:   rd_mux = C_S_AXI_DATA_WIDTH'({new_flag, STUCK_O, EN_I});
      default:     rd_mux = '0;
    endcase
  end

  // Local-bus read response
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      LB_RFINISH <= 1'b0;
      LB_RDATA   <= '0;
    end else begin
      LB_RFINISH <= LB_RREQ;
      if (LB_RREQ) LB_RDATA <= rd_mux;
    end
  end

endmodule
